// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer for the 8-bit processing unit.
// Drives every register load, bus mux select and the memory write strobe.
module control_unit #(
  parameter int word_size  = 8,
  parameter int op_size    = 4,
  parameter int state_size = 4,
  parameter int Sel1_size  = 3,
  parameter int Sel2_size  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [word_size-1:0] instruction,
  input  logic                 zero,
  output logic                 Load_R0,
  output logic                 Load_R1,
  output logic                 Load_R2,
  output logic                 Load_R3,
  output logic                 Load_PC,
  output logic                 Inc_PC,
  output logic [Sel1_size-1:0] Sel_Bus_1_Mux,
  output logic [Sel2_size-1:0] Sel_Bus_2_Mux,
  output logic                 Load_IR,
  output logic                 Load_Add_R,
  output logic                 Load_Reg_Y,
  output logic                 Load_Reg_Z,
  output logic                 write,
  output logic                 halted
);

  typedef enum logic [state_size-1:0] {
    S_idle, S_fet1, S_fet2, S_dec,
    S_ex1,  S_rd1,  S_rd2,  S_wr1,
    S_wr2,  S_br1,  S_br2,  S_halt
  } state_t;

  localparam logic [op_size-1:0] OP_NOP = 0;
  localparam logic [op_size-1:0] OP_ADD = 1;
  localparam logic [op_size-1:0] OP_SUB = 2;
  localparam logic [op_size-1:0] OP_AND = 3;
  localparam logic [op_size-1:0] OP_NOT = 4;
  localparam logic [op_size-1:0] OP_RD  = 5;
  localparam logic [op_size-1:0] OP_WR  = 6;
  localparam logic [op_size-1:0] OP_BR  = 7;
  localparam logic [op_size-1:0] OP_BRZ = 8;

  localparam logic [Sel1_size-1:0] SEL1_PC  = Sel1_size'(4);
  localparam logic [Sel2_size-1:0] SEL2_ALU = Sel2_size'(0);
  localparam logic [Sel2_size-1:0] SEL2_B1  = Sel2_size'(1);
  localparam logic [Sel2_size-1:0] SEL2_MEM = Sel2_size'(2);

  state_t state_q, state_d;

  logic [op_size-1:0]   opcode;
  logic [Sel1_size-1:0] sel_src, sel_dest;
  logic [3:0]           dest_ld, ld_r;

  assign opcode   = instruction[word_size-1 -: op_size];
  assign sel_src  = Sel1_size'(instruction[3:2]);
  assign sel_dest = Sel1_size'(instruction[1:0]);
  assign dest_ld  = 4'b0001 << instruction[1:0];

  assign Load_R0 = ld_r[0];
  assign Load_R1 = ld_r[1];
  assign Load_R2 = ld_r[2];
  assign Load_R3 = ld_r[3];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_idle;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    ld_r          = '0;
    Load_PC       = 1'b0;
    Inc_PC        = 1'b0;
    Sel_Bus_1_Mux = '0;
    Sel_Bus_2_Mux = '0;
    Load_IR       = 1'b0;
    Load_Add_R    = 1'b0;
    Load_Reg_Y    = 1'b0;
    Load_Reg_Z    = 1'b0;
    write         = 1'b0;
    halted        = 1'b0;
    case (state_q)
      S_idle: state_d = S_fet1;
      S_fet1: begin
        Sel_Bus_1_Mux = SEL1_PC;
        Sel_Bus_2_Mux = SEL2_B1;
        Load_Add_R    = 1'b1;
        Inc_PC        = 1'b1;
        state_d       = S_fet2;
      end
      S_fet2: begin
        Sel_Bus_2_Mux = SEL2_MEM;
        Load_IR       = 1'b1;
        state_d       = S_dec;
      end
      S_dec: begin
        case (opcode)
          OP_NOP: state_d = S_fet1;
          OP_ADD, OP_SUB, OP_AND: begin
            Sel_Bus_1_Mux = sel_src;
            Sel_Bus_2_Mux = SEL2_B1;
            Load_Reg_Y    = 1'b1;
            state_d       = S_ex1;
          end
          OP_NOT: begin
            Sel_Bus_1_Mux = sel_src;
            Sel_Bus_2_Mux = SEL2_ALU;
            Load_Reg_Z    = 1'b1;
            ld_r          = dest_ld;
            state_d       = S_fet1;
          end
          OP_RD, OP_WR, OP_BR, OP_BRZ: begin
            // Untaken BRZ only steps the PC past its address word
            if (opcode == OP_BRZ && !zero) begin
              Inc_PC  = 1'b1;
              state_d = S_fet1;
            end else begin
              Sel_Bus_1_Mux = SEL1_PC;
              Sel_Bus_2_Mux = SEL2_B1;
              Load_Add_R    = 1'b1;
              state_d       = (opcode == OP_RD) ? S_rd1 :
                              (opcode == OP_WR) ? S_wr1 : S_br1;
            end
          end
          default: state_d = S_halt;
        endcase
      end
      S_ex1: begin
        Sel_Bus_1_Mux = sel_dest;
        Sel_Bus_2_Mux = SEL2_ALU;
        Load_Reg_Z    = 1'b1;
        ld_r          = dest_ld;
        state_d       = S_fet1;
      end
      S_rd1, S_wr1: begin
        Sel_Bus_2_Mux = SEL2_MEM;
        Load_Add_R    = 1'b1;
        Inc_PC        = 1'b1;
        state_d       = (state_q == S_rd1) ? S_rd2 : S_wr2;
      end
      S_rd2: begin
        Sel_Bus_2_Mux = SEL2_MEM;
        ld_r          = dest_ld;
        state_d       = S_fet1;
      end
      S_wr2: begin
        Sel_Bus_1_Mux = sel_src;
        write         = 1'b1;
        state_d       = S_fet1;
      end
      S_br1: begin
        Sel_Bus_2_Mux = SEL2_MEM;
        Load_Add_R    = 1'b1;
        state_d       = S_br2;
      end
      S_br2: begin
        Sel_Bus_2_Mux = SEL2_MEM;
        Load_PC       = 1'b1;
        state_d       = S_fet1;
      end
      S_halt: begin
        halted  = 1'b1;
        state_d = S_halt;
      end
      default: state_d = S_halt;
    endcase
  end

endmodule
